// File: rtl/tb_mem_arb_pkg.sv
// Shared types and constants for the testbench memory arbiter.
package tb_mem_arb_pkg;

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} arb_src_e;

  localparam logic [3:0] InstrBe = 4'hF;

endpackage

// File: rtl/tb_arb_id_fifo.sv
// In-order FIFO of granted-request source IDs; synchronous active-low clear.
module tb_arb_id_fifo
  import tb_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type         src_t = arb_src_e
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic                     pop,
  input  src_t                     wdata,
  output src_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  src_t            mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointer overflow is the wrap to 0.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Arbitrates instr/data buses onto one req/gnt/rvalid memory and routes responses by ID.
// Define TB_MEM_ARB_RR_EN for round-robin; otherwise data has fixed priority over instr.
module tb_mem_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int unsigned DW       = 33,
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          instr_req_i,
  input  logic [AW-1:0] instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic          mem_err_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          proto_err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTS) + 1;

  arb_src_e        sel, head, contend_pick, lock_src_q;
  logic            lock_q, issue_ok, granted, resp_ok, proto_err_q;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

`ifdef TB_MEM_ARB_RR_EN
  arb_src_e last_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)      last_q <= SRC_INSTR;
    else if (granted) last_q <= sel;
  end

  assign contend_pick = (last_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
`else
  assign contend_pick = SRC_DATA;
`endif

  always_comb begin
    sel = SRC_INSTR;
    if (lock_q)                         sel = lock_src_q;
    else if (data_req_i && instr_req_i) sel = contend_pick;
    else if (data_req_i)                sel = SRC_DATA;
  end

  // Registered count only: a same-cycle pop does not reopen a slot.
  assign issue_ok  = rstn_i & (fifo_count < CntW'(MAX_OUTS));
  assign mem_req_o = issue_ok & (instr_req_i | data_req_i);
  assign granted   = mem_req_o & mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = InstrBe;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (sel == SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = granted & (sel == SRC_INSTR);
  assign data_gnt_o  = granted & (sel == SRC_DATA);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel;
    end else if (granted) begin
      lock_q     <= 1'b0;
    end
  end

  tb_arb_id_fifo #(
    .Depth (MAX_OUTS),
    .src_t (arb_src_e)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (granted & ~fifo_full),
    .pop    (resp_ok),
    .wdata  (sel),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign resp_ok        = rstn_i & mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = resp_ok & (head == SRC_INSTR);
  assign data_rvalid_o  = resp_ok & (head == SRC_DATA);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i[31:0];
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)                         proto_err_q <= 1'b0;
    else if (mem_rvalid_i && fifo_empty) proto_err_q <= 1'b1;
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Scoreboard bench for tb_mem_arbiter: directed stimulus queues expected responses, a monitor checks them.
module tb_tb_mem_arbiter;

  logic        clk, rstn;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [32:0] data_wdata, data_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err, proto_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [32:0] mem_wdata, mem_rdata;

  typedef struct {
    logic        src;
    logic [32:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef TB_MEM_ARB_RR_EN
  localparam logic WIN_B = 1'b0;
`else
  localparam logic WIN_B = 1'b1;
`endif

  tb_mem_arbiter #(.DW(33), .AW(32), .MAX_OUTS(4)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_err_i      (mem_err),
    .mem_rdata_i    (mem_rdata),
    .proto_err_o    (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req  = 1'b0; instr_addr = '0;
    data_req   = 1'b0; data_we    = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_gnt    = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
  endtask

  task automatic rsp(input logic src, input logic [32:0] d, input logic e);
    exp_t x;
    x.src = src; x.data = d; x.err = e;
    q.push_back(x);
    mem_rvalid = 1'b1; mem_rdata = d; mem_err = e;
  endtask

  // Response monitor: every port rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (instr_rvalid || data_rvalid) begin
      if (q.size() == 0) begin
        chk("spurious_rvalid", {62'd0, instr_rvalid, data_rvalid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_instr_rvalid", 64'(instr_rvalid), 64'(!e.src));
        chk("rsp_data_rvalid",  64'(data_rvalid),  64'(e.src));
        if (e.src) begin
          chk("rsp_data_rdata", 64'(data_rdata), 64'(e.data));
          chk("rsp_data_err",   64'(data_err),   64'(e.err));
        end else begin
          chk("rsp_instr_rdata", 64'(instr_rdata), 64'(e.data[31:0]));
          chk("rsp_instr_err",   64'(instr_err),   64'(e.err));
        end
      end
    end
  end

  initial begin
    // Reset: everything forced quiet even with all inputs active.
    idle();
    rstn = 1'b0; instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    #2;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_gnts",    64'({instr_gnt, data_gnt}), 64'd0);
    chk("rst_rvalids", 64'({instr_rvalid, data_rvalid}), 64'd0);
    repeat (2) cyc();
    idle(); rstn = 1'b1; #2;
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_idle_req",  64'(mem_req), 64'd0);

    // T1: single instr fetch, response two cycles after grant.
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h8000_0000; mem_gnt = 1'b1; #2;
    chk("t1_mem_req",   64'(mem_req), 64'd1);
    chk("t1_instr_gnt", 64'(instr_gnt), 64'd1);
    chk("t1_data_gnt",  64'(data_gnt), 64'd0);
    chk("t1_addr",      64'(mem_addr), 64'h8000_0000);
    chk("t1_we_be",     64'({mem_we, mem_be}), 64'h0F);
    chk("t1_wdata",     64'(mem_wdata), 64'd0);
    cyc(); idle();
    cyc(); idle(); rsp(1'b0, 33'h0_0000_0013, 1'b0);

    // T2: contention with immediate grants.
    cyc(); idle();
    instr_req = 1'b1; instr_addr = 32'h0000_1000;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3; data_addr = 32'h0000_2000;
    data_wdata = 33'h1_1234_5678; mem_gnt = 1'b1; #2;
    chk("t2_data_gnt",  64'(data_gnt), 64'd1);
    chk("t2_instr_gnt", 64'(instr_gnt), 64'd0);
    chk("t2_addr",      64'(mem_addr), 64'h2000);
    chk("t2_we_be",     64'({mem_we, mem_be}), 64'h13);
    chk("t2_wdata",     64'(mem_wdata), 64'h1_1234_5678);
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h0000_1000; mem_gnt = 1'b1; #2;
    chk("t2_instr_gnt2", 64'(instr_gnt), 64'd1);
    chk("t2_addr2",      64'(mem_addr), 64'h1000);
    chk("t2_wdata2",     64'(mem_wdata), 64'd0);
    cyc(); idle(); rsp(1'b1, 33'h1_0000_00AA, 1'b0);
    cyc(); idle(); rsp(1'b0, 33'h1_DEAD_00BB, 1'b1);

    // T2b: data granted last, then contention: RR favours instr, fixed favours data.
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h3000; mem_gnt = 1'b1;
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h3100; data_req = 1'b1; data_addr = 32'h3200;
    mem_gnt = 1'b1; #2;
    chk("t2b_data_gnt",  64'(data_gnt), 64'(WIN_B));
    chk("t2b_instr_gnt", 64'(instr_gnt), 64'(!WIN_B));
    cyc(); idle(); mem_gnt = 1'b1;
    if (WIN_B) begin instr_req = 1'b1; instr_addr = 32'h3100; end
    else begin data_req = 1'b1; data_addr = 32'h3200; end
    #2;
    chk("t2b_second_gnt", 64'({instr_gnt, data_gnt}), WIN_B ? 64'h2 : 64'h1);
    cyc(); idle(); rsp(1'b1, 33'h0_0000_0C01, 1'b0);
    cyc(); idle(); rsp(WIN_B, 33'h0_0000_0C02, 1'b0);
    cyc(); idle(); rsp(!WIN_B, 33'h0_0000_0C03, 1'b0);

    // T3: stalled grant keeps instr locked despite a higher-priority data request.
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h0000_4000; #2;
    chk("t3_c0_addr", 64'({mem_req, mem_addr}), {31'd0, 1'b1, 32'h4000});
    for (int i = 1; i < 3; i++) begin
      cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h0000_4000;
      data_req = 1'b1; data_addr = 32'h0000_5000; #2;
      chk("t3_locked_addr", 64'(mem_addr), 64'h4000);
      chk("t3_data_wait",   64'(data_gnt), 64'd0);
    end
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h0000_4000;
    data_req = 1'b1; data_addr = 32'h0000_5000; mem_gnt = 1'b1; #2;
    chk("t3_gnt_instr", 64'({instr_gnt, data_gnt, mem_addr}), {30'd0, 2'b10, 32'h4000});
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h0000_5000; mem_gnt = 1'b1; #2;
    chk("t3_gnt_data", 64'({instr_gnt, data_gnt, mem_addr}), {30'd0, 2'b01, 32'h5000});
    cyc(); idle(); rsp(1'b0, 33'h0_0000_0D01, 1'b0);
    cyc(); idle(); rsp(1'b1, 33'h1_0000_0D02, 1'b0);

    // T4: fill to MAX_OUTS, full blocks, full+pop still blocks, pointer wrap.
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); data_req = 1'b1; data_addr = 32'h100 + 32'(4 * k); mem_gnt = 1'b1; #2;
      chk("t4_fill_gnt", 64'(data_gnt), 64'd1);
    end
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h110; mem_gnt = 1'b1; #2;
    chk("t4_full_block", 64'({mem_req, data_gnt, instr_gnt}), 64'd0);
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h110; mem_gnt = 1'b1;
    rsp(1'b1, 33'h0_0000_0040, 1'b0); #2;
    chk("t4_full_pop_block", 64'({mem_req, data_gnt}), 64'd0);
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h110; mem_gnt = 1'b1; #2;
    chk("t4_after_pop_issue", 64'({mem_req, data_gnt}), 64'h3);
    cyc(); idle(); rsp(1'b1, 33'h0_0000_0041, 1'b0);
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h114; mem_gnt = 1'b1;
    rsp(1'b1, 33'h0_0000_0042, 1'b0); #2;
    chk("t4_push_pop_gnt", 64'(data_gnt), 64'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); rsp(1'b1, 33'h0_0000_0043 + 33'(k), 1'b0);
    end

    // T5: rvalid with empty FIFO is dropped and sets the sticky error.
    cyc(); idle(); mem_rvalid = 1'b1; mem_rdata = 33'h0_0000_0077; #2;
    chk("t5_dropped", 64'({instr_rvalid, data_rvalid}), 64'd0);
    cyc(); idle(); #2;
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    repeat (3) cyc();
    chk("t5_proto_sticky", 64'(proto_err), 64'd1);

    // T6: reset with two outstanding, then a stray rvalid.
    cyc(); idle(); instr_req = 1'b1; instr_addr = 32'h600; mem_gnt = 1'b1;
    cyc(); idle(); data_req = 1'b1; data_addr = 32'h604; mem_gnt = 1'b1;
    cyc(); idle(); rstn = 1'b0; instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
    mem_rvalid = 1'b1; #2;
    chk("t6_rst_req", 64'({mem_req, instr_gnt, data_gnt}), 64'd0);
    chk("t6_rst_rvalid", 64'({instr_rvalid, data_rvalid}), 64'd0);
    cyc(); idle(); rstn = 1'b1; #2;
    chk("t6_proto_cleared", 64'(proto_err), 64'd0);
    cyc(); idle(); mem_rvalid = 1'b1; mem_rdata = 33'h0_0000_0099; #2;
    chk("t6_stray_dropped", 64'({instr_rvalid, data_rvalid}), 64'd0);
    cyc(); idle(); #2;
    chk("t6_stray_proto_err", 64'(proto_err), 64'd1);

    cyc(); idle();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
